rename_rat: RTL and testbench
=============================

// Module: rename_rat
// PURPOSE
//   2-wide register rename stage. Sits between decode and dispatch/ROB, directly downstream of
//   the freelist. Maps logical sources to physical registers via a speculative RAT and takes new
//   destination pregs from the freelist alloc ports. Keeps an architectural RAT, updated at
//   commit, that restores the speculative RAT on ROB rollback.
// PARAMETERS
//   NUM_LREGS       32  logical (architectural) registers
//   LREG_IDX_WIDTH  5   logical index width
//   PREG_IDX_WIDTH  6   physical index width (64 pregs)
//   AVAIL_WIDTH     6   width of fl_avail_count
// PORTS
//   clock            in   1   single clock
//   reset            in   1   asynchronous, active-high reset
//   instrN_valid     in   1   decode slot N valid (N=0,1; slot 0 older)
//   instrN_lrs1/lrs2 in   5   slot N logical sources
//   instrN_lrd       in   5   slot N logical destination
//   instrN_need_wb   in   1   slot N writes lrd
//   instr_ready      out  1   both slots accepted this cycle (all-or-nothing)
//   fl_reqN_valid    out  1   freelist alloc request N
//   fl_reqN_data     in   6   preg returned by freelist port N (combinational)
//   fl_avail_count   in   AVAIL_WIDTH  free pregs currently available
//   outN_valid       out  1   renamed slot N valid (registered)
//   outN_prs1/prs2   out  6   physical sources
//   outN_prd         out  6   new physical destination
//   outN_old_prd     out  6   previous mapping of lrd (ROB frees it at commit)
//   outN_need_wb     out  1   copy of need_wb
//   out_ready        in   1   dispatch accepts the output register
//   commitN_valid    in   1   commit slot N retires a writing instr (slot 0 older)
//   commitN_lrd      in   5   retired logical destination
//   commitN_prd      in   6   retired physical destination
//   rob_state        in   2   ROB_STATE_IDLE / ROB_STATE_ROLLBACK / ROB_STATE_WALK
// BEHAVIOUR
//   - Reset: spec_rat[i] = arch_rat[i] = i. All outN_* = 0. instr_ready = 0 while reset is high.
//   - alloc_cnt = (instr0_valid & need_wb0) + (instr1_valid & need_wb1).
//   - instr_ready = is_idle & (!out0_valid & !out1_valid | out_ready) & (fl_avail_count >= alloc_cnt).
//   - fire = instr_ready & (instr0_valid | instr1_valid).
//   - Allocation is compacted. The first allocating slot uses fl_req0 and the second uses
//     fl_req1. If only slot 1 allocates, it drives fl_req0_valid and takes fl_req0_data.
//     fl_reqN_valid is asserted only when fire is high.
//   - Sources: prsX = spec_rat[lrsX]. Slot 1 bypass: if instr0 writes and lrs == instr0_lrd,
//     slot 1 gets slot 0's new prd. old_prd follows the same bypass.
//   - Non-writing slot: prd = 0 and old_prd = 0, with no alloc and no RAT write.
//   - RAT write at fire. If both slots write the same lrd, slot 1's prd wins.
//   - Latency: 1 cycle from fire to outN_valid. Outputs hold stable while out_ready = 0.
//     The output register clears when out_ready = 1 and fire = 0.
//   - Commit: arch_rat[commitN_lrd] <= commitN_prd in any rob_state. Same lrd: commit1 wins.
//   - ROLLBACK: spec_rat <= arch_rat next-state, including same-cycle commits.
//     All outN_valid <= 0. instr_ready = 0. A pending output is discarded even if out_ready = 1.
//   - WALK: instr_ready = 0 and spec_rat holds. The output register drains normally.
//   - Reset mid-operation restores the reset state asynchronously. Any in-flight output is dropped.
// CONFIGURATION
//   RENAME_X0_ZERO_EN defined:
//     - lrd == 0 is treated as need_wb = 0: no alloc, no RAT write, prd = 0.
//     - Sources with lrs == 0 read preg 0.
//     - Commit to lrd 0 is ignored.
//   RENAME_X0_ZERO_EN undefined: logical x0 is renamed like any other register.
// TESTING
//   - Reset, then instr0 lrd=3 and instr1 lrd=4 with fl_req data 32/33:
//     out0 prd=32, old_prd=3; out1 prd=33, old_prd=4. A later read of x3 gives prs=32.
//   - Intra-group dependency: instr0 lrd=5 -> prd 40. instr1 lrs1=5, lrd=5 ->
//     out1 prs1=40, old_prd=40, and spec_rat[5] = instr1 prd.
//   - fl_avail_count=1 with both slots writing: instr_ready=0, fl_req*_valid=0, outputs unchanged.
//     Raising the count to 2 lets the pair fire.
//   - out_ready=0 for 3 cycles: outputs stable and instr_ready=0.
//     out_ready=1 with a new pair accepts the pair in the same cycle.
//   - Rename x7 -> 45, commit nothing, then ROLLBACK: next lookup of x7 gives 7 and
//     outputs are invalid. If commit7->45 occurs in the rollback cycle, the lookup gives 45.
//   - RENAME_X0_ZERO_EN: instr0 lrd=0, need_wb=1 -> fl_req0_valid=0 and prd=0.
//     With the macro undefined, the same stimulus allocates.

Source files
------------

// File: rtl/rename_rat.sv
// Two-wide register rename stage with speculative and architectural RATs.
// Optional RENAME_X0_ZERO_EN hardwires logical x0 to physical preg 0.
module rename_rat #(
  parameter int NUM_LREGS      = 32,
  parameter int LREG_IDX_WIDTH = 5,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int AVAIL_WIDTH    = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      instr0_valid,
  input  logic [LREG_IDX_WIDTH-1:0] instr0_lrs1,
  input  logic [LREG_IDX_WIDTH-1:0] instr0_lrs2,
  input  logic [LREG_IDX_WIDTH-1:0] instr0_lrd,
  input  logic                      instr0_need_wb,
  input  logic                      instr1_valid,
  input  logic [LREG_IDX_WIDTH-1:0] instr1_lrs1,
  input  logic [LREG_IDX_WIDTH-1:0] instr1_lrs2,
  input  logic [LREG_IDX_WIDTH-1:0] instr1_lrd,
  input  logic                      instr1_need_wb,
  output logic                      instr_ready,
  output logic                      fl_req0_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req0_data,
  output logic                      fl_req1_valid,
  input  logic [PREG_IDX_WIDTH-1:0] fl_req1_data,
  input  logic [AVAIL_WIDTH-1:0]    fl_avail_count,
  output logic                      out0_valid,
  output logic [PREG_IDX_WIDTH-1:0] out0_prs1,
  output logic [PREG_IDX_WIDTH-1:0] out0_prs2,
  output logic [PREG_IDX_WIDTH-1:0] out0_prd,
  output logic [PREG_IDX_WIDTH-1:0] out0_old_prd,
  output logic                      out0_need_wb,
  output logic                      out1_valid,
  output logic [PREG_IDX_WIDTH-1:0] out1_prs1,
  output logic [PREG_IDX_WIDTH-1:0] out1_prs2,
  output logic [PREG_IDX_WIDTH-1:0] out1_prd,
  output logic [PREG_IDX_WIDTH-1:0] out1_old_prd,
  output logic                      out1_need_wb,
  input  logic                      out_ready,
  input  logic                      commit0_valid,
  input  logic [LREG_IDX_WIDTH-1:0] commit0_lrd,
  input  logic [PREG_IDX_WIDTH-1:0] commit0_prd,
  input  logic                      commit1_valid,
  input  logic [LREG_IDX_WIDTH-1:0] commit1_lrd,
  input  logic [PREG_IDX_WIDTH-1:0] commit1_prd,
  input  logic [1:0]                rob_state
);

  // Any state other than idle/rollback (i.e. walk) stalls rename and freezes spec_rat.
  localparam logic [1:0] ROB_STATE_IDLE     = 2'd0;
  localparam logic [1:0] ROB_STATE_ROLLBACK = 2'd1;

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_WIDTH-1:0] prs1;
    logic [PREG_IDX_WIDTH-1:0] prs2;
    logic [PREG_IDX_WIDTH-1:0] prd;
    logic [PREG_IDX_WIDTH-1:0] old_prd;
    logic                      need_wb;
  } slot_t;

  logic [PREG_IDX_WIDTH-1:0] spec_rat_q [NUM_LREGS];
  logic [PREG_IDX_WIDTH-1:0] spec_rat_d [NUM_LREGS];
  logic [PREG_IDX_WIDTH-1:0] arch_rat_q [NUM_LREGS];
  logic [PREG_IDX_WIDTH-1:0] arch_rat_d [NUM_LREGS];
  slot_t out_q [2];
  slot_t out_d [2];
  slot_t ren   [2];

  logic                      w0, w1, c0_en, c1_en;
  logic [1:0]                alloc_cnt;
  logic                      is_idle, is_rollback, fire;
  logic [PREG_IDX_WIDTH-1:0] prd0, prd1;

  always_comb begin
    w0    = instr0_valid & instr0_need_wb;
    w1    = instr1_valid & instr1_need_wb;
    c0_en = commit0_valid;
    c1_en = commit1_valid;
`ifdef RENAME_X0_ZERO_EN
    if (instr0_lrd == '0) w0 = 1'b0;
    if (instr1_lrd == '0) w1 = 1'b0;
    if (commit0_lrd == '0) c0_en = 1'b0;
    if (commit1_lrd == '0) c1_en = 1'b0;
`endif
  end

  assign alloc_cnt   = {1'b0, w0} + {1'b0, w1};
  assign is_idle     = (rob_state == ROB_STATE_IDLE);
  assign is_rollback = (rob_state == ROB_STATE_ROLLBACK);
  assign instr_ready = ~reset & is_idle
                     & ((~out_q[0].valid & ~out_q[1].valid) | out_ready)
                     & (fl_avail_count >= AVAIL_WIDTH'(alloc_cnt));
  assign fire        = instr_ready & (instr0_valid | instr1_valid);

  // Compacted allocation: the first writing slot always takes freelist port 0.
  assign fl_req0_valid = fire & (w0 | w1);
  assign fl_req1_valid = fire & w0 & w1;
  assign prd0 = w0 ? fl_req0_data : '0;
  assign prd1 = w1 ? (w0 ? fl_req1_data : fl_req0_data) : '0;

  always_comb begin
    ren[0] = '0;
    ren[1] = '0;
    if (instr0_valid) begin
      ren[0].valid   = 1'b1;
      ren[0].prs1    = spec_rat_q[instr0_lrs1];
      ren[0].prs2    = spec_rat_q[instr0_lrs2];
      ren[0].prd     = prd0;
      ren[0].old_prd = w0 ? spec_rat_q[instr0_lrd] : '0;
      ren[0].need_wb = w0;
`ifdef RENAME_X0_ZERO_EN
      if (instr0_lrs1 == '0) ren[0].prs1 = '0;
      if (instr0_lrs2 == '0) ren[0].prs2 = '0;
`endif
    end
    if (instr1_valid) begin
      ren[1].valid   = 1'b1;
      ren[1].prs1    = (w0 && instr1_lrs1 == instr0_lrd) ? prd0 : spec_rat_q[instr1_lrs1];
      ren[1].prs2    = (w0 && instr1_lrs2 == instr0_lrd) ? prd0 : spec_rat_q[instr1_lrs2];
      ren[1].prd     = prd1;
      ren[1].old_prd = !w1 ? '0 :
                       (w0 && instr1_lrd == instr0_lrd) ? prd0 : spec_rat_q[instr1_lrd];
      ren[1].need_wb = w1;
`ifdef RENAME_X0_ZERO_EN
      if (instr1_lrs1 == '0) ren[1].prs1 = '0;
      if (instr1_lrs2 == '0) ren[1].prs2 = '0;
`endif
    end
  end

  // Rollback copies the post-commit arch RAT so same-cycle retirements survive.
  always_comb begin
    arch_rat_d = arch_rat_q;
    if (c0_en) arch_rat_d[commit0_lrd] = commit0_prd;
    if (c1_en) arch_rat_d[commit1_lrd] = commit1_prd;
    spec_rat_d = spec_rat_q;
    if (is_rollback) begin
      spec_rat_d = arch_rat_d;
    end else if (fire) begin
      if (w0) spec_rat_d[instr0_lrd] = prd0;
      if (w1) spec_rat_d[instr1_lrd] = prd1;
    end
  end

  always_comb begin
    out_d = out_q;
    if (is_rollback) begin
      out_d[0] = '0;
      out_d[1] = '0;
    end else if (fire) begin
      out_d = ren;
    end else if (out_ready) begin
      out_d[0] = '0;
      out_d[1] = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LREGS; i++) begin
        spec_rat_q[i] <= PREG_IDX_WIDTH'(i);
        arch_rat_q[i] <= PREG_IDX_WIDTH'(i);
      end
      out_q[0] <= '0;
      out_q[1] <= '0;
    end else begin
      spec_rat_q <= spec_rat_d;
      arch_rat_q <= arch_rat_d;
      out_q      <= out_d;
    end
  end

  assign out0_valid   = out_q[0].valid;
  assign out0_prs1    = out_q[0].prs1;
  assign out0_prs2    = out_q[0].prs2;
  assign out0_prd     = out_q[0].prd;
  assign out0_old_prd = out_q[0].old_prd;
  assign out0_need_wb = out_q[0].need_wb;
  assign out1_valid   = out_q[1].valid;
  assign out1_prs1    = out_q[1].prs1;
  assign out1_prs2    = out_q[1].prs2;
  assign out1_prd     = out_q[1].prd;
  assign out1_old_prd = out_q[1].old_prd;
  assign out1_need_wb = out_q[1].need_wb;

endmodule

// File: tb/tb_rename_rat.sv
// Testbench for rename_rat: directed scenarios plus randomized traffic against
// a sequential-rename reference model.
module tb_rename_rat;
  localparam logic [1:0] IDLE = 2'd0, RB = 2'd1, WALK = 2'd2;

  logic       clock, reset;
  logic       instr0_valid, instr0_need_wb, instr1_valid, instr1_need_wb;
  logic [4:0] instr0_lrs1, instr0_lrs2, instr0_lrd, instr1_lrs1, instr1_lrs2, instr1_lrd;
  logic       instr_ready, fl_req0_valid, fl_req1_valid;
  logic [5:0] fl_req0_data, fl_req1_data, fl_avail_count;
  logic       out0_valid, out0_need_wb, out1_valid, out1_need_wb, out_ready;
  logic [5:0] out0_prs1, out0_prs2, out0_prd, out0_old_prd;
  logic [5:0] out1_prs1, out1_prs2, out1_prd, out1_old_prd;
  logic       commit0_valid, commit1_valid;
  logic [4:0] commit0_lrd, commit1_lrd;
  logic [5:0] commit0_prd, commit1_prd;
  logic [1:0] rob_state;

  rename_rat dut (
    .clock(clock), .reset(reset),
    .instr0_valid(instr0_valid), .instr0_lrs1(instr0_lrs1), .instr0_lrs2(instr0_lrs2),
    .instr0_lrd(instr0_lrd), .instr0_need_wb(instr0_need_wb),
    .instr1_valid(instr1_valid), .instr1_lrs1(instr1_lrs1), .instr1_lrs2(instr1_lrs2),
    .instr1_lrd(instr1_lrd), .instr1_need_wb(instr1_need_wb),
    .instr_ready(instr_ready),
    .fl_req0_valid(fl_req0_valid), .fl_req0_data(fl_req0_data),
    .fl_req1_valid(fl_req1_valid), .fl_req1_data(fl_req1_data),
    .fl_avail_count(fl_avail_count),
    .out0_valid(out0_valid), .out0_prs1(out0_prs1), .out0_prs2(out0_prs2),
    .out0_prd(out0_prd), .out0_old_prd(out0_old_prd), .out0_need_wb(out0_need_wb),
    .out1_valid(out1_valid), .out1_prs1(out1_prs1), .out1_prs2(out1_prs2),
    .out1_prd(out1_prd), .out1_old_prd(out1_old_prd), .out1_need_wb(out1_need_wb),
    .out_ready(out_ready),
    .commit0_valid(commit0_valid), .commit0_lrd(commit0_lrd), .commit0_prd(commit0_prd),
    .commit1_valid(commit1_valid), .commit1_lrd(commit1_lrd), .commit1_prd(commit1_prd),
    .rob_state(rob_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [5:0] m_spec [32];
  logic [5:0] m_arch [32];
  bit         m_ov [2];
  logic [5:0] m_p1 [2], m_p2 [2], m_pd [2], m_po [2];
  bit         m_wb [2];
  bit         exp_ready, exp_req0, exp_req1;
  logic       got_ready, got_req0, got_req1;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_spec[i] = 6'(i);
      m_arch[i] = 6'(i);
    end
    for (int s = 0; s < 2; s++) begin
      m_ov[s] = 0; m_p1[s] = 0; m_p2[s] = 0; m_pd[s] = 0; m_po[s] = 0; m_wb[s] = 0;
    end
  endtask

  task automatic set_slot(input int s, input bit v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input bit wb);
    if (s == 0) begin
      instr0_valid = v; instr0_lrs1 = a; instr0_lrs2 = b; instr0_lrd = d; instr0_need_wb = wb;
    end else begin
      instr1_valid = v; instr1_lrs1 = a; instr1_lrs2 = b; instr1_lrd = d; instr1_need_wb = wb;
    end
  endtask

  task automatic clear_inputs();
    set_slot(0, 0, 0, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0);
    commit0_valid = 0; commit0_lrd = 0; commit0_prd = 0;
    commit1_valid = 0; commit1_lrd = 0; commit1_prd = 0;
    rob_state = IDLE; out_ready = 1; fl_avail_count = 6'd63;
    fl_req0_data = 0; fl_req1_data = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  // Renames the group one slot at a time against a scratch table: later slots
  // naturally see earlier slots' new mappings, and the last writer wins.
  task automatic cycle();
    logic [5:0] tmp [32];
    logic [5:0] fl [2];
    bit v [2], w [2];
    logic [4:0] s1 [2], s2 [2], d [2];
    logic [5:0] p1 [2], p2 [2], pd [2], po [2];
    int n, k;
    bit fire;
    #2;
    v[0] = instr0_valid; s1[0] = instr0_lrs1; s2[0] = instr0_lrs2; d[0] = instr0_lrd;
    v[1] = instr1_valid; s1[1] = instr1_lrs1; s2[1] = instr1_lrs2; d[1] = instr1_lrd;
    w[0] = instr0_valid && instr0_need_wb;
    w[1] = instr1_valid && instr1_need_wb;
`ifdef RENAME_X0_ZERO_EN
    for (int s = 0; s < 2; s++) if (d[s] == 0) w[s] = 0;
`endif
    n = int'(w[0]) + int'(w[1]);
    exp_ready = !reset && rob_state == IDLE && ((!m_ov[0] && !m_ov[1]) || out_ready)
                && int'(fl_avail_count) >= n;
    fire = exp_ready && (v[0] || v[1]);
    exp_req0 = fire && n >= 1;
    exp_req1 = fire && n == 2;
    got_ready = instr_ready; got_req0 = fl_req0_valid; got_req1 = fl_req1_valid;
    fl[0] = fl_req0_data; fl[1] = fl_req1_data;
    tmp = m_spec;
    k = 0;
    for (int s = 0; s < 2; s++) begin
      p1[s] = 0; p2[s] = 0; pd[s] = 0; po[s] = 0;
      if (v[s]) begin
        p1[s] = tmp[s1[s]];
        p2[s] = tmp[s2[s]];
`ifdef RENAME_X0_ZERO_EN
        if (s1[s] == 0) p1[s] = 0;
        if (s2[s] == 0) p2[s] = 0;
`endif
        if (w[s]) begin
          pd[s] = fl[k];
          k++;
          po[s] = tmp[d[s]];
          tmp[d[s]] = pd[s];
        end
      end
    end
    @(posedge clock);
    if (commit0_valid) m_arch[commit0_lrd] = commit0_prd;
    if (commit1_valid) m_arch[commit1_lrd] = commit1_prd;
`ifdef RENAME_X0_ZERO_EN
    m_arch[0] = 6'd0;
`endif
    if (rob_state == RB) begin
      m_spec = m_arch;
      m_ov[0] = 0; m_ov[1] = 0;
    end else if (fire) begin
      m_spec = tmp;
      for (int s = 0; s < 2; s++) begin
        m_ov[s] = v[s]; m_p1[s] = p1[s]; m_p2[s] = p2[s];
        m_pd[s] = pd[s]; m_po[s] = po[s]; m_wb[s] = w[s];
      end
    end else if (out_ready) begin
      m_ov[0] = 0; m_ov[1] = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    set_slot(0, 1, 1, 2, 3, 1);
    model_reset();
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", instr_ready);
    end
    checks++;
    if ({out0_valid, out0_prd, out0_prs1, out1_valid, out1_prd, out1_old_prd} !== '0) begin
      errors++; $display("FAIL reset_outputs got %b/%0d/%0d %b/%0d/%0d exp all zero",
                         out0_valid, out0_prd, out0_prs1, out1_valid, out1_prd, out1_old_prd);
    end
    @(posedge clock);
    #1;
    reset = 0;
    clear_inputs();
    set_slot(0, 1, 9, 31, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd9 || out0_prs2 !== 6'd31) begin
      errors++; $display("FAIL reset_identity got %0d/%0d exp 9/31", out0_prs1, out0_prs2);
    end
  endtask

  task automatic test_basic_pair();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 3, 1);
    set_slot(1, 1, 5, 6, 4, 1);
    fl_req0_data = 6'd32; fl_req1_data = 6'd33;
    cycle();
    checks++;
    if (got_ready !== 1'b1 || got_req0 !== 1'b1 || got_req1 !== 1'b1) begin
      errors++; $display("FAIL pair_handshake got %b%b%b exp 111", got_ready, got_req0, got_req1);
    end
    checks++;
    if ({out0_valid, out0_prd, out0_old_prd} !== {1'b1, 6'd32, 6'd3}) begin
      errors++; $display("FAIL pair_out0 got v=%b prd=%0d old=%0d exp 1/32/3",
                         out0_valid, out0_prd, out0_old_prd);
    end
    checks++;
    if ({out1_valid, out1_prd, out1_old_prd} !== {1'b1, 6'd33, 6'd4}) begin
      errors++; $display("FAIL pair_out1 got v=%b prd=%0d old=%0d exp 1/33/4",
                         out1_valid, out1_prd, out1_old_prd);
    end
    set_slot(0, 1, 3, 4, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0);
    cycle();
    checks++;
    if ({out0_prs1, out0_prs2, out0_prd, out1_valid} !== {6'd32, 6'd33, 6'd0, 1'b0}) begin
      errors++; $display("FAIL pair_lookup got prs1=%0d prs2=%0d prd=%0d v1=%b exp 32/33/0/0",
                         out0_prs1, out0_prs2, out0_prd, out1_valid);
    end
  endtask

  task automatic test_intra_dep();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 1, 5, 1);
    set_slot(1, 1, 5, 2, 5, 1);
    fl_req0_data = 6'd40; fl_req1_data = 6'd41;
    cycle();
    checks++;
    if ({out1_prs1, out1_old_prd, out1_prd} !== {6'd40, 6'd40, 6'd41}) begin
      errors++; $display("FAIL dep_bypass got prs1=%0d old=%0d prd=%0d exp 40/40/41",
                         out1_prs1, out1_old_prd, out1_prd);
    end
    set_slot(0, 1, 5, 0, 0, 0);
    set_slot(1, 0, 0, 0, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd41) begin
      errors++; $display("FAIL dep_last_writer got %0d exp 41", out0_prs1);
    end
  endtask

  task automatic test_avail();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 10, 1);
    set_slot(1, 1, 3, 4, 11, 1);
    fl_req0_data = 6'd50; fl_req1_data = 6'd51;
    fl_avail_count = 6'd1;
    cycle();
    checks++;
    if ({got_ready, got_req0, got_req1, out0_valid, out1_valid} !== 5'b0) begin
      errors++; $display("FAIL avail_short got rdy=%b req=%b%b v=%b%b exp all 0",
                         got_ready, got_req0, got_req1, out0_valid, out1_valid);
    end
    fl_avail_count = 6'd2;
    cycle();
    checks++;
    if ({got_ready, out0_prd, out1_prd} !== {1'b1, 6'd50, 6'd51}) begin
      errors++; $display("FAIL avail_enough got rdy=%b prd=%0d/%0d exp 1/50/51",
                         got_ready, out0_prd, out1_prd);
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 8, 1);
    set_slot(1, 1, 3, 4, 9, 1);
    fl_req0_data = 6'd20; fl_req1_data = 6'd21;
    cycle();
    set_slot(0, 1, 8, 9, 10, 1);
    set_slot(1, 1, 10, 9, 11, 1);
    fl_req0_data = 6'd22; fl_req1_data = 6'd23;
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({got_ready, got_req0, out0_valid, out0_prd, out1_prd} !== {1'b0, 1'b0, 1'b1, 6'd20, 6'd21}) begin
        errors++; $display("FAIL stall_hold[%0d] got rdy=%b req0=%b v0=%b prd=%0d/%0d exp 0/0/1/20/21",
                           i, got_ready, got_req0, out0_valid, out0_prd, out1_prd);
      end
    end
    out_ready = 1;
    cycle();
    checks++;
    if ({got_ready, out0_prd, out1_prd, out0_prs1, out1_prs1} !== {1'b1, 6'd22, 6'd23, 6'd20, 6'd22}) begin
      errors++; $display("FAIL stall_release got rdy=%b prd=%0d/%0d prs1=%0d/%0d exp 1/22/23/20/22",
                         got_ready, out0_prd, out1_prd, out0_prs1, out1_prs1);
    end
  endtask

  task automatic test_rollback();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 7, 1);
    fl_req0_data = 6'd45;
    cycle();
    set_slot(0, 1, 1, 2, 12, 1);
    rob_state = RB;
    cycle();
    checks++;
    if ({got_ready, out0_valid, out1_valid} !== 3'b0) begin
      errors++; $display("FAIL rollback_flush got rdy=%b v=%b%b exp 000", got_ready, out0_valid, out1_valid);
    end
    rob_state = IDLE;
    set_slot(0, 1, 7, 12, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd7 || out0_prs2 !== 6'd12) begin
      errors++; $display("FAIL rollback_restore got %0d/%0d exp 7/12", out0_prs1, out0_prs2);
    end
    set_slot(0, 1, 1, 2, 7, 1);
    fl_req0_data = 6'd45;
    cycle();
    set_slot(0, 0, 0, 0, 0, 0);
    rob_state = RB;
    commit0_valid = 1; commit0_lrd = 5'd7; commit0_prd = 6'd45;
    cycle();
    clear_inputs();
    set_slot(0, 1, 7, 0, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd45) begin
      errors++; $display("FAIL rollback_commit got %0d exp 45", out0_prs1);
    end
  endtask

  task automatic test_walk();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 13, 1);
    fl_req0_data = 6'd55;
    out_ready = 0;
    cycle();
    rob_state = WALK;
    cycle();
    checks++;
    if ({got_ready, out0_valid, out0_prd} !== {1'b0, 1'b1, 6'd55}) begin
      errors++; $display("FAIL walk_hold got rdy=%b v=%b prd=%0d exp 0/1/55", got_ready, out0_valid, out0_prd);
    end
    out_ready = 1;
    cycle();
    checks++;
    if (out0_valid !== 1'b0) begin
      errors++; $display("FAIL walk_drain got %b exp 0", out0_valid);
    end
    rob_state = IDLE;
    set_slot(0, 1, 13, 0, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd55) begin
      errors++; $display("FAIL walk_keep got %0d exp 55", out0_prs1);
    end
  endtask

  task automatic test_x0();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 0, 0, 0, 1);
    fl_req0_data = 6'd60;
    cycle();
`ifdef RENAME_X0_ZERO_EN
    checks++;
    if ({got_req0, out0_prd, out0_need_wb} !== {1'b0, 6'd0, 1'b0}) begin
      errors++; $display("FAIL x0_zero got req0=%b prd=%0d wb=%b exp 0/0/0", got_req0, out0_prd, out0_need_wb);
    end
`else
    checks++;
    if ({got_req0, out0_prd, out0_old_prd} !== {1'b1, 6'd60, 6'd0}) begin
      errors++; $display("FAIL x0_renamed got req0=%b prd=%0d old=%0d exp 1/60/0", got_req0, out0_prd, out0_old_prd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    apply_reset();
    set_slot(0, 1, 1, 2, 14, 1);
    set_slot(1, 1, 3, 4, 15, 1);
    fl_req0_data = 6'd30; fl_req1_data = 6'd31;
    out_ready = 0;
    cycle();
    reset = 1;
    #1;
    checks++;
    if ({instr_ready, out0_valid, out1_valid, out0_prd} !== 9'b0) begin
      errors++; $display("FAIL midreset_clear got rdy=%b v=%b%b prd=%0d exp 0/00/0",
                         instr_ready, out0_valid, out1_valid, out0_prd);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 0;
    clear_inputs();
    set_slot(0, 1, 14, 15, 0, 0);
    cycle();
    checks++;
    if (out0_prs1 !== 6'd14 || out0_prs2 !== 6'd15) begin
      errors++; $display("FAIL midreset_rat got %0d/%0d exp 14/15", out0_prs1, out0_prs2);
    end
  endtask

  task automatic test_random();
    logic       o_v [2], o_wb [2];
    logic [5:0] o_p1 [2], o_p2 [2], o_pd [2], o_po [2];
    int r;
    clear_inputs();
    apply_reset();
    for (int it = 0; it < 500; it++) begin
      set_slot(0, 1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      set_slot(1, 1'($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      fl_req0_data = 6'($urandom); fl_req1_data = 6'($urandom);
      fl_avail_count = 6'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 3) != 0);
      commit0_valid = 1'($urandom); commit0_lrd = 5'($urandom); commit0_prd = 6'($urandom);
      commit1_valid = 1'($urandom); commit1_lrd = 5'($urandom); commit1_prd = 6'($urandom);
      r = int'($urandom_range(0, 15));
      rob_state = (r == 0) ? RB : (r == 1) ? WALK : IDLE;
      cycle();
      checks++;
      if ({got_ready, got_req0, got_req1} !== {exp_ready, exp_req0, exp_req1}) begin
        errors++; $display("FAIL rand_handshake it=%0d got %b%b%b exp %b%b%b", it,
                           got_ready, got_req0, got_req1, exp_ready, exp_req0, exp_req1);
      end
      o_v[0] = out0_valid; o_p1[0] = out0_prs1; o_p2[0] = out0_prs2;
      o_pd[0] = out0_prd; o_po[0] = out0_old_prd; o_wb[0] = out0_need_wb;
      o_v[1] = out1_valid; o_p1[1] = out1_prs1; o_p2[1] = out1_prs2;
      o_pd[1] = out1_prd; o_po[1] = out1_old_prd; o_wb[1] = out1_need_wb;
      for (int s = 0; s < 2; s++) begin
        checks++;
        if (o_v[s] !== m_ov[s]) begin
          errors++; $display("FAIL rand_valid it=%0d slot%0d got %b exp %b", it, s, o_v[s], m_ov[s]);
        end else if (m_ov[s]) begin
          checks++;
          if ({o_p1[s], o_p2[s], o_pd[s], o_po[s], o_wb[s]} !== {m_p1[s], m_p2[s], m_pd[s], m_po[s], m_wb[s]}) begin
            errors++;
            $display("FAIL rand_fields it=%0d slot%0d got %0d/%0d/%0d/%0d/%b exp %0d/%0d/%0d/%0d/%b",
                     it, s, o_p1[s], o_p2[s], o_pd[s], o_po[s], o_wb[s],
                     m_p1[s], m_p2[s], m_pd[s], m_po[s], m_wb[s]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_intra_dep();
    test_avail();
    test_back_to_back();
    test_rollback();
    test_walk();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
